// File: rtl/error_calc_sequencer_pkg.sv
// Shared types for the error_calc front-end sequencer.
// State encoding, default widths and the output flag bundle.
package lcplc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  localparam int SEQ_DATA_WIDTH_DEF     = 16;
  localparam int SEQ_BLOCK_SIZE_LOG_DEF = 8;
  localparam int SEQ_BAND_WIDTH_DEF     = 8;
  localparam int SEQ_BLOCK_CNT_WIDTH_DEF = 12;

  typedef struct packed {
    logic last_s;
    logic last_b;
    logic last_i;
    logic first_band;
  } seq_flags_t;

endpackage

// File: rtl/error_calc_sequencer_axis_stage.sv
// Single-entry valid/ready register slice.
// Accepts a new word while draining the held one, so no bubble.
module seq_axis_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Load on input handshake, otherwise empty on output handshake.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Slice register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/error_calc_sequencer.sv
// Tags a raw sample stream with slice/band/image boundary flags.
// Define ERROR_CALC_SEQ_PROGRESS_EN to expose cur_band/cur_block.
module error_calc_sequencer
  import lcplc_seq_pkg::*;
#(
  parameter int DATA_WIDTH      = SEQ_DATA_WIDTH_DEF,
  parameter int BLOCK_SIZE_LOG  = SEQ_BLOCK_SIZE_LOG_DEF,
  parameter int BAND_WIDTH      = SEQ_BAND_WIDTH_DEF,
  parameter int BLOCK_CNT_WIDTH = SEQ_BLOCK_CNT_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [BAND_WIDTH-1:0]      cfg_bands,
  input  logic [BLOCK_CNT_WIDTH-1:0] cfg_blocks,
  input  logic                       x_in_valid,
  output logic                       x_in_ready,
  input  logic [DATA_WIDTH-1:0]      x_in_data,
  output logic                       x_out_valid,
  input  logic                       x_out_ready,
  output logic [DATA_WIDTH-1:0]      x_out_data,
  output logic                       x_out_last_s,
  output logic                       x_out_last_b,
  output logic                       x_out_last_i,
  output logic                       x_out_first_band,
  output logic                       busy
`ifdef ERROR_CALC_SEQ_PROGRESS_EN
  ,
  output logic [BAND_WIDTH-1:0]      cur_band,
  output logic [BLOCK_CNT_WIDTH-1:0] cur_block
`endif
);

  localparam int FW = $bits(seq_flags_t);
`ifdef ERROR_CALC_SEQ_PROGRESS_EN
  localparam int PW = DATA_WIDTH + FW + BAND_WIDTH + BLOCK_CNT_WIDTH;
`else
  localparam int PW = DATA_WIDTH + FW;
`endif

  seq_state_t                 state_q, state_d;
  logic [BLOCK_SIZE_LOG-1:0]  sample_q, sample_d;
  logic [BAND_WIDTH-1:0]      band_q, band_d;
  logic [BAND_WIDTH-1:0]      bands_q, bands_d;
  logic [BLOCK_CNT_WIDTH-1:0] block_q, block_d;
  logic [BLOCK_CNT_WIDTH-1:0] blocks_q, blocks_d;

  seq_flags_t flags;
  seq_flags_t out_flags;
  logic       st_in_valid;
  logic       st_in_ready;
  logic       in_fire;
  logic       cfg_fire;
  logic       out_fire;
  logic [PW-1:0] st_in_data;
  logic [PW-1:0] st_out_data;

  assign cfg_ready   = rst && (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign st_in_valid = x_in_valid && (state_q == RUN);
  assign x_in_ready  = st_in_ready && (state_q == RUN);
  assign in_fire     = st_in_valid && st_in_ready;
  assign cfg_fire    = cfg_valid && cfg_ready;
  assign out_fire    = x_out_valid && x_out_ready;

  // Boundary flags for the sample about to be accepted.
  always_comb begin
    flags.last_s     = &sample_q;
    flags.last_b     = flags.last_s && (band_q == bands_q);
    flags.last_i     = flags.last_b && (block_q == blocks_q);
    flags.first_band = (band_q == '0);
  end

`ifdef ERROR_CALC_SEQ_PROGRESS_EN
  assign st_in_data = {x_in_data, flags, band_q, block_q};
  assign {x_out_data, out_flags, cur_band, cur_block} = st_out_data;
`else
  assign st_in_data = {x_in_data, flags};
  assign {x_out_data, out_flags} = st_out_data;
`endif

  assign x_out_last_s     = out_flags.last_s;
  assign x_out_last_b     = out_flags.last_b;
  assign x_out_last_i     = out_flags.last_i;
  assign x_out_first_band = out_flags.first_band;

  // Sequencer FSM and nested sample/band/block counters.
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    band_d   = band_q;
    block_d  = block_q;
    bands_d  = bands_q;
    blocks_d = blocks_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_fire) begin
          bands_d  = cfg_bands;
          blocks_d = cfg_blocks;
          sample_d = '0;
          band_d   = '0;
          block_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (in_fire) begin
          sample_d = sample_q + BLOCK_SIZE_LOG'(1);
          if (flags.last_s) begin
            band_d = flags.last_b ? '0
                                  : band_q + BAND_WIDTH'(1);
          end
          if (flags.last_b) begin
            block_d = flags.last_i ? '0
                                   : block_q + BLOCK_CNT_WIDTH'(1);
          end
          if (flags.last_i) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!x_out_valid || out_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      sample_q <= '0;
      band_q   <= '0;
      block_q  <= '0;
      bands_q  <= '0;
      blocks_q <= '0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      band_q   <= band_d;
      block_q  <= block_d;
      bands_q  <= bands_d;
      blocks_q <= blocks_d;
    end
  end

  seq_axis_stage #(
    .WIDTH (PW)
  ) u_stage (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (st_in_valid),
    .in_ready  (st_in_ready),
    .in_data   (st_in_data),
    .out_valid (x_out_valid),
    .out_ready (x_out_ready),
    .out_data  (st_out_data)
  );

endmodule

// File: tb/tb_error_calc_sequencer.sv
// Bench for error_calc_sequencer with a small block size.
// Expected tags come from block/band/sample arithmetic on the output index.
module tb_error_calc_sequencer;

  localparam int DW  = 16;
  localparam int BSL = 2;
  localparam int BS  = 1 << BSL;
  localparam int BW  = 8;
  localparam int BCW = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [BW-1:0]  cfg_bands;
  logic [BCW-1:0] cfg_blocks;
  logic           x_in_valid;
  logic           x_in_ready;
  logic [DW-1:0]  x_in_data;
  logic           x_out_valid;
  logic           x_out_ready;
  logic [DW-1:0]  x_out_data;
  logic           x_out_last_s;
  logic           x_out_last_b;
  logic           x_out_last_i;
  logic           x_out_first_band;
  logic           busy;
`ifdef ERROR_CALC_SEQ_PROGRESS_EN
  logic [BW-1:0]  cur_band;
  logic [BCW-1:0] cur_block;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  error_calc_sequencer #(
    .DATA_WIDTH      (DW),
    .BLOCK_SIZE_LOG  (BSL),
    .BAND_WIDTH      (BW),
    .BLOCK_CNT_WIDTH (BCW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_bands        (cfg_bands),
    .cfg_blocks       (cfg_blocks),
    .x_in_valid       (x_in_valid),
    .x_in_ready       (x_in_ready),
    .x_in_data        (x_in_data),
    .x_out_valid      (x_out_valid),
    .x_out_ready      (x_out_ready),
    .x_out_data       (x_out_data),
    .x_out_last_s     (x_out_last_s),
    .x_out_last_b     (x_out_last_b),
    .x_out_last_i     (x_out_last_i),
    .x_out_first_band (x_out_first_band),
    .busy             (busy)
`ifdef ERROR_CALC_SEQ_PROGRESS_EN
    ,
    .cur_band         (cur_band),
    .cur_block        (cur_block)
`endif
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_band(int n, int bands);
    return (n / BS) % (bands + 1);
  endfunction

  function automatic int m_block(int n, int bands);
    return n / (BS * (bands + 1));
  endfunction

  // {last_s, last_b, last_i, first_band} for output number n of an image
  function automatic logic [3:0] m_flags(int n, int bands, int blocks);
    logic ls, lb, li, fb;
    ls = (n % BS) == BS - 1;
    lb = ls && (m_band(n, bands) == bands);
    li = lb && (m_block(n, bands) == blocks);
    fb = m_band(n, bands) == 0;
    return {ls, lb, li, fb};
  endfunction

  function automatic logic [3:0] out_flags();
    return {x_out_last_s, x_out_last_b, x_out_last_i, x_out_first_band};
  endfunction

  // Offer a config from the current negedge and wait for its handshake.
  task automatic start_cfg(int bands, int blocks);
    int n = 0;
    x_in_valid = 1'b0;
    cfg_valid  = 1'b1;
    cfg_bands  = BW'(bands);
    cfg_blocks = BCW'(blocks);
    #1;
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("cfg_ready_wait", cfg_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    #1;
    chk("busy_after_cfg", busy, 1);
  endtask

  // Push one image through, checking every emitted sample.
  task automatic stream(int bands, int blocks, bit rnd, int abort_at, bit pend);
    int total = BS * (bands + 1) * (blocks + 1);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic [DW-1:0] dat[$];
    bit hold = 0;
    logic [DW+3:0] held = '0;
    if (pend) begin
      cfg_valid  = 1'b1;
      cfg_bands  = '0;
      cfg_blocks = '0;
    end
    while (got < total && cyc < 2000 &&
           !(abort_at >= 0 && sent >= abort_at)) begin
      @(negedge clk);
      if (hold) chk("stable", {x_out_data, out_flags()}, held);
      x_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      x_in_valid  = (sent < total && rnd) ? ($urandom_range(0, 3) != 0) : 1'b1;
      x_in_data   = rnd ? DW'($urandom) : DW'(sent);
      #1;
      if (pend) chk("cfg_blocked", cfg_ready, 0);
      if (sent == total) chk("drain_no_take", x_in_ready, 0);
      if (!rnd && sent < total) chk("full_rate", x_in_ready, 1);
      if (!rnd && sent > 0) begin
        chk("lat_valid", x_out_valid, 1);
        chk("lat_count", got, sent - 1);
      end
      if (x_out_valid && x_out_ready) begin
        chk("data", x_out_data, dat[got]);
        chk("flags", out_flags(), m_flags(got, bands, blocks));
`ifdef ERROR_CALC_SEQ_PROGRESS_EN
        chk("cur_band", cur_band, m_band(got, bands));
        chk("cur_block", cur_block, m_block(got, bands));
`endif
        got++;
      end
      hold = x_out_valid && !x_out_ready;
      held = {x_out_data, out_flags()};
      if (x_in_valid && x_in_ready) begin
        dat.push_back(x_in_data);
        sent++;
      end
      cyc++;
    end
    if (abort_at < 0) begin
      chk("stream_done", got, total);
      @(negedge clk);
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_valid", x_out_valid, 0);
      chk("idle_cfg_ready", cfg_ready, 1);
      chk("idle_no_take", x_in_ready, 0);
    end
  endtask

  initial begin
    rst = 1'b0;
    cfg_valid = 1'b0;
    cfg_bands = '0;
    cfg_blocks = '0;
    x_in_valid = 1'b0;
    x_in_data = '0;
    x_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", x_out_valid, 0);
    chk("rst_data", x_out_data, 0);
    chk("rst_flags", out_flags(), 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_in_ready", x_in_ready, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    #1;
    chk("idle_cfg_ready0", cfg_ready, 1);
    x_in_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_in_ready", x_in_ready, 0);
    chk("idle_out_valid", x_out_valid, 0);

    // 3 bands x 2 blocks, ready high
    start_cfg(2, 1);
    stream(2, 1, 1'b0, -1, 1'b0);

    // same shape, random back-pressure, cfg held pending
    start_cfg(2, 1);
    stream(2, 1, 1'b1, -1, 1'b1);

    // the pending single-band single-block config
    start_cfg(0, 0);
    stream(0, 0, 1'b0, -1, 1'b0);

    // reset in the middle of an image
    start_cfg(2, 1);
    stream(2, 1, 1'b0, 6, 1'b0);
    rst = 1'b0;
    x_in_valid = 1'b0;
    x_out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_valid", x_out_valid, 0);
    chk("mid_rst_data", x_out_data, 0);
    chk("mid_rst_flags", out_flags(), 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cfg_ready", cfg_ready, 0);
    rst = 1'b1;
    #1;
    chk("post_rst_cfg_ready", cfg_ready, 1);
    start_cfg(0, 0);
    stream(0, 0, 1'b1, -1, 1'b0);

    // 3 bands x 2 blocks, random back-pressure
    start_cfg(2, 1);
    stream(2, 1, 1'b1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
